// File: rtl/bsr_pkg.sv
// Shared types and constants for the bsr barrel shifter and its pass scheduler.
package bsr_pkg;

    localparam int   DW        = 16;
    localparam int   AMT_W     = 4;
    localparam int   MAX_STEP  = 7;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bsr.sv
// Combinational 16-bit logical barrel shifter: 0-7 positions per pass, zero-fill.
module bsr
    import bsr_pkg::*;
(
    input  logic [DW-1:0] din,
    input  logic [2:0]    shiftcnt,
    input  logic          shiftdr,
    output logic [DW-1:0] dout
);

    always_comb begin
        if (shiftdr == DIR_RIGHT) dout = din >> shiftcnt;
        else                      dout = din << shiftcnt;
    end

endmodule

// File: rtl/bsr_shift_sched.sv
// Round-robin front end for bsr: splits 0-15 position shifts into passes of at most
// MAX_STEP through an accumulator and returns the tagged result over valid/ready.
module bsr_shift_sched
    import bsr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [DW-1:0]    r0_data,
    input  logic [AMT_W-1:0] r0_amt,
    input  logic             r0_dir,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [DW-1:0]    r1_data,
    input  logic [AMT_W-1:0] r1_amt,
    input  logic             r1_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_id,
    output logic             busy
);

    localparam logic [AMT_W-1:0] MAX_STEP_W = AMT_W'(MAX_STEP);

    state_e           state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic [AMT_W-1:0] step;
    logic [AMT_W-1:0] rem_left;
    logic [DW-1:0]    shifted;
    logic             grant_any;
    logic             grant_id;
    logic             in_idle;

    assign step     = (rem_q > MAX_STEP_W) ? MAX_STEP_W : rem_q;
    assign rem_left = rem_q - step;

    bsr u_bsr (
        .din      (acc_q),
        .shiftcnt (step[2:0]),
        .shiftdr  (dir_q),
        .dout     (shifted)
    );

    // Contention goes to rr_ptr; a lone requester wins regardless of the pointer.
    assign grant_any = r0_valid | r1_valid;
    assign grant_id  = (r0_valid & r1_valid) ? rr_ptr_q : r1_valid;
    assign in_idle   = rst_n && (state_q == IDLE);
    assign r0_ready  = in_idle && grant_any && !grant_id;
    assign r1_ready  = in_idle && grant_any && grant_id;

    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_id    = out_valid & id_q;
    assign busy      = (state_q == SHIFT) || (state_q == DONE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    acc_d    = grant_id ? r1_data : r0_data;
                    rem_d    = grant_id ? r1_amt  : r0_amt;
                    dir_d    = grant_id ? r1_dir  : r0_dir;
                    id_d     = grant_id;
                    rr_ptr_d = ~grant_id;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted;
                rem_d = rem_left;
                if (rem_left == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            dir_q    <= DIR_LEFT;
            id_q     <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
